// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: per-channel synchroniser, debounce
// qualification, acquisition timeout, loss-of-lock counting, combined status.
module pll_lock_monitor #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 2500,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                    clkin1,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       lock,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       lost,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH*CNT_W-1:0] loss_cnt,
  output logic                    all_locked,
  output logic                    chk_ok
);

  localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [NUM_CH-1:0]                  sync_first;
  logic [SYNC_STAGES-2:0][NUM_CH-1:0] sync_rest;
  logic [NUM_CH-1:0]                  lock_s;

  // First synchroniser stage: captures the asynchronous lock, never reset
  always_ff @(posedge clkin1) begin
    sync_first <= lock;
  end

  // Remaining synchroniser stages, reset so lock_s starts at 0
  always_ff @(posedge clkin1) begin
    if (rst) begin
      sync_rest <= '0;
    end else begin
      sync_rest[0] <= sync_first;
      for (int s = 1; s < int'(SYNC_STAGES) - 1; s++) begin
        sync_rest[s] <= sync_rest[s-1];
      end
    end
  end

  assign lock_s = sync_rest[SYNC_STAGES-2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               lost_q, lost_d;
    logic               tmo_q, tmo_d;
    logic               locked_q;

    // Per-channel state, timer, debounce count and sticky status registers
    always_ff @(posedge clkin1) begin
      if (rst) begin
        state_q  <= ST_WAIT;
        timer_q  <= '0;
        stb_q    <= '0;
        cnt_q    <= '0;
        lost_q   <= 1'b0;
        tmo_q    <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        timer_q  <= timer_d;
        stb_q    <= stb_d;
        cnt_q    <= cnt_d;
        lost_q   <= lost_d;
        tmo_q    <= tmo_d;
        locked_q <= (state_d == ST_LOCKED);
      end
    end

    // Next-state logic; clr drops sticky status but a same-cycle event wins
    always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      stb_d     = stb_q;
      lost_d    = clr ? 1'b0 : lost_q;
      tmo_d     = clr ? 1'b0 : tmo_q;
      cnt_d     = clr ? '0 : cnt_q;
      timer_inc = (timer_q == TMR_W'(LOCK_TIMEOUT)) ? timer_q : timer_q + TMR_W'(1);
      cnt_inc   = clr ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));

      unique case (state_q)
        ST_WAIT: begin
          timer_d = timer_inc;
          if (lock_s[i]) begin
            stb_d   = STB_W'(1);
            state_d = (STABLE_CYCLES == 1) ? ST_LOCKED : ST_QUAL;
          end
        end
        ST_QUAL: begin
          timer_d = timer_inc;
          if (!lock_s[i]) begin
            state_d = ST_WAIT;
            stb_d   = '0;
          end else if (stb_q == STB_W'(STABLE_CYCLES - 1)) begin
            state_d = ST_LOCKED;
          end else begin
            stb_d = stb_q + STB_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!lock_s[i]) begin
            state_d = ST_WAIT;
            timer_d = '0;
            stb_d   = '0;
            lost_d  = 1'b1;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = ST_WAIT;
          timer_d = '0;
          stb_d   = '0;
        end
      endcase

      // Acquisition window expiry while still waiting or qualifying
      if ((state_q != ST_LOCKED) && (timer_inc == TMR_W'(LOCK_TIMEOUT))) begin
        tmo_d = 1'b1;
      end
    end

    assign locked[i]                  = locked_q;
    assign lost[i]                    = lost_q;
    assign timeout[i]                 = tmo_q;
    assign loss_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign all_locked = &locked;

  // Registered overall health for downstream reset release / status LED
  always_ff @(posedge clkin1) begin
    if (rst) begin
      chk_ok <= 1'b0;
    end else begin
      chk_ok <= all_locked & ~(|lost) & ~(|timeout);
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: a default two-channel instance
// driven from a vector table, and a one-channel CNT_W=2 instance driven by
// a hand-written sequence for saturation and clr/loss collision.
module tb_pll_lock_monitor;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [1:0]  lock;
  logic [1:0]  locked, lost, timeout;
  logic [15:0] loss_cnt;
  logic        all_locked, chk_ok;

  logic        rst2, clr2;
  logic [0:0]  lock2, locked2, lost2, timeout2;
  logic [1:0]  loss_cnt2;
  logic        all_locked2, chk_ok2;

  always #5 clk = ~clk;

  pll_lock_monitor dut (
    .clkin1(clk), .rst(rst), .lock(lock), .clr(clr),
    .locked(locked), .lost(lost), .timeout(timeout), .loss_cnt(loss_cnt),
    .all_locked(all_locked), .chk_ok(chk_ok)
  );

  pll_lock_monitor #(
    .NUM_CH(1), .SYNC_STAGES(2), .STABLE_CYCLES(1), .LOCK_TIMEOUT(20), .CNT_W(2)
  ) dut2 (
    .clkin1(clk), .rst(rst2), .lock(lock2), .clr(clr2),
    .locked(locked2), .lost(lost2), .timeout(timeout2), .loss_cnt(loss_cnt2),
    .all_locked(all_locked2), .chk_ok(chk_ok2)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  lock;
    logic        clr;
    int unsigned adv;
    logic [1:0]  e_locked, e_lost, e_tmo;
    logic [15:0] e_cnt;
    logic        e_all, e_ok;
  } vec_t;

  typedef struct {
    int unsigned due;
    int unsigned id;
    bit          d2;
    logic [1:0]  locked, lost, tmo;
    logic [15:0] cnt;
    logic        all, ok;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  exp_t        cur;
  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  a_locked, a_lost, a_tmo;
  logic [15:0] a_cnt;
  logic        a_all, a_ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input logic r, input logic [1:0] l, input logic c, input int unsigned adv,
                     input logic [1:0] el, input logic [1:0] elo, input logic [1:0] et,
                     input logic [15:0] ec, input logic ea, input logic eo);
    vec_t v;
    v.rst = r; v.lock = l; v.clr = c; v.adv = adv;
    v.e_locked = el; v.e_lost = elo; v.e_tmo = et; v.e_cnt = ec; v.e_all = ea; v.e_ok = eo;
    tbl.push_back(v);
  endtask

  task automatic push(input bit d2, input int unsigned adv, input int unsigned id,
                      input logic [1:0] el, input logic [1:0] elo, input logic [1:0] et,
                      input logic [15:0] ec, input logic ea, input logic eo);
    exp_t e;
    e.due = cyc + adv; e.id = id; e.d2 = d2;
    e.locked = el; e.lost = elo; e.tmo = et; e.cnt = ec; e.all = ea; e.ok = eo;
    sb.push_back(e);
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each expectation on the falling edge of its due cycle
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      n_vec++;
      a_locked = cur.d2 ? {1'b0, locked2}   : locked;
      a_lost   = cur.d2 ? {1'b0, lost2}     : lost;
      a_tmo    = cur.d2 ? {1'b0, timeout2}  : timeout;
      a_cnt    = cur.d2 ? {14'b0, loss_cnt2} : loss_cnt;
      a_all    = cur.d2 ? all_locked2 : all_locked;
      a_ok     = cur.d2 ? chk_ok2     : chk_ok;
      if (cur.due != cyc || a_locked !== cur.locked || a_lost !== cur.lost || a_tmo !== cur.tmo ||
          a_cnt !== cur.cnt || a_all !== cur.all || a_ok !== cur.ok) begin
        n_err++;
        $display("FAIL %s vec%0d cyc%0d(due %0d): locked=%b/%b lost=%b/%b timeout=%b/%b loss_cnt=%h/%h all_locked=%b/%b chk_ok=%b/%b (got/want)",
                 cur.d2 ? "dut2" : "dut", cur.id, cyc, cur.due, a_locked, cur.locked, a_lost, cur.lost,
                 a_tmo, cur.tmo, a_cnt, cur.cnt, a_all, cur.all, a_ok, cur.ok);
      end
    end
  end

  initial begin
    rst = 1'b1; lock = 2'b00; clr = 1'b0;
    rst2 = 1'b1; lock2 = 1'b0; clr2 = 1'b0;

    //  rst lock  clr adv   locked lost   tmo    cnt       all   ok
    // lock rise
    add(1, 2'b00, 0, 5,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b00, 0, 5,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 18,   2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);
    // ch1 loss x3, 5 cycles low each
    add(0, 2'b01, 0, 3,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);
    add(0, 2'b01, 0, 1,    2'b01, 2'b10, 2'b00, 16'h0100, 1'b0, 1'b1);
    add(0, 2'b01, 0, 1,    2'b01, 2'b10, 2'b00, 16'h0100, 1'b0, 1'b0);
    add(0, 2'b11, 0, 19,   2'b11, 2'b10, 2'b00, 16'h0100, 1'b1, 1'b0);
    add(0, 2'b01, 0, 5,    2'b01, 2'b10, 2'b00, 16'h0200, 1'b0, 1'b0);
    add(0, 2'b11, 0, 19,   2'b11, 2'b10, 2'b00, 16'h0200, 1'b1, 1'b0);
    add(0, 2'b01, 0, 5,    2'b01, 2'b10, 2'b00, 16'h0300, 1'b0, 1'b0);
    add(0, 2'b11, 0, 19,   2'b11, 2'b10, 2'b00, 16'h0300, 1'b1, 1'b0);
    add(0, 2'b11, 1, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);
    // reset while LOCKED, then ch0 debounce 10 high / 2 low / 40 high
    add(1, 2'b11, 0, 1,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(1, 2'b00, 0, 4,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b00, 0, 2,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 10,   2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b00, 0, 2,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 18,   2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 1,    2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 21,   2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    // reset while ch1 qualifies, then relock with lock-rise timing
    add(0, 2'b11, 0, 8,    2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(1, 2'b00, 0, 1,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(1, 2'b00, 0, 2,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b00, 0, 1,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 18,   2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);
    // ch1 timeout at 2500, late lock, clr
    add(1, 2'b01, 0, 1,    2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 2499, 2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b01, 0, 1,    2'b01, 2'b00, 2'b10, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 18,   2'b01, 2'b00, 2'b10, 16'h0000, 1'b0, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b10, 16'h0000, 1'b1, 1'b0);
    add(0, 2'b11, 1, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0);
    add(0, 2'b11, 0, 1,    2'b11, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);

    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      rst = tbl[k].rst; lock = tbl[k].lock; clr = tbl[k].clr;
      push(1'b0, tbl[k].adv, k, tbl[k].e_locked, tbl[k].e_lost, tbl[k].e_tmo,
           tbl[k].e_cnt, tbl[k].e_all, tbl[k].e_ok);
      run(tbl[k].adv);
    end

    // dut2: timeout at 20, STABLE_CYCLES=1 lock, saturation, clr collision
    rst2 = 1'b0; lock2 = 1'b0;
    push(1'b1, 19, 100, 2'b0, 2'b0, 2'b0, 16'd0, 1'b0, 1'b0); run(19);
    push(1'b1, 1,  101, 2'b0, 2'b0, 2'b1, 16'd0, 1'b0, 1'b0); run(1);
    lock2 = 1'b1;
    push(1'b1, 2,  102, 2'b0, 2'b0, 2'b1, 16'd0, 1'b0, 1'b0); run(2);
    push(1'b1, 1,  103, 2'b1, 2'b0, 2'b1, 16'd0, 1'b1, 1'b0); run(1);
    clr2 = 1'b1;
    push(1'b1, 1,  104, 2'b1, 2'b0, 2'b0, 16'd0, 1'b1, 1'b0); run(1);
    clr2 = 1'b0;
    push(1'b1, 1,  105, 2'b1, 2'b0, 2'b0, 16'd0, 1'b1, 1'b1); run(1);
    for (int k = 1; k <= 5; k++) begin
      lock2 = 1'b0;
      push(1'b1, 3, 110 + 2*k, 2'b0, 2'b1, 2'b0, 16'((k < 3) ? k : 3), 1'b0, (k == 1));
      run(3);
      lock2 = 1'b1;
      push(1'b1, 3, 111 + 2*k, 2'b1, 2'b1, 2'b0, 16'((k < 3) ? k : 3), 1'b1, 1'b0);
      run(3);
    end
    lock2 = 1'b0;
    push(1'b1, 2,  130, 2'b1, 2'b1, 2'b0, 16'd3, 1'b1, 1'b0); run(2);
    clr2 = 1'b1;
    push(1'b1, 1,  131, 2'b0, 2'b1, 2'b0, 16'd1, 1'b0, 1'b0); run(1);
    clr2 = 1'b0;
    push(1'b1, 1,  132, 2'b0, 2'b1, 2'b0, 16'd1, 1'b0, 1'b0); run(1);

    repeat (3) @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL vec%0d: expectation due cyc%0d never compared (now cyc%0d)", cur.id, cur.due, cyc);
    end

    // End-of-run state of both instances
    if (locked !== 2'b11 || chk_ok !== 1'b1 || timeout !== 2'b00) begin
      n_err++;
      $display("FAIL final dut: locked=%b chk_ok=%b timeout=%b", locked, chk_ok, timeout);
    end
    if (loss_cnt2 !== 2'd1) begin
      n_err++;
      $display("FAIL final dut2: loss_cnt=%0d want 1", loss_cnt2);
    end
    if (lost2 !== 1'b1 || locked2 !== 1'b0) begin
      n_err++;
      $display("FAIL final dut2: lost=%b locked=%b", lost2, locked2);
    end
    if (n_vec != tbl.size() + 19) begin
      n_err++;
      $display("FAIL vector count %0d want %0d", n_vec, tbl.size() + 19);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Synthesizable, multi-channel PLL lock supervisor. Replaces the bench-only lock check with RTL that can stay in the design. Each channel:
- synchronises an asynchronous PLL `lock` into the monitor clock domain;
- qualifies lock with a debounce window;
- flags lock-acquisition timeout;
- counts loss-of-lock events.

A combined `chk_ok` drives the top-level status LED / reset release logic after the PLL IP instances.

## Interface
Parameters:
- `NUM_CH`, 2: number of monitored PLL lock inputs (1..8).
- `SYNC_STAGES`, 3: synchroniser flops per channel (2..4).
- `STABLE_CYCLES`, 16: consecutive synchronised-high cycles required to declare lock (≥1).
- `LOCK_TIMEOUT`, 2500: clkin1 cycles allowed from reset or loss until lock is declared (50 µs at 50 MHz).
- `CNT_W`, 8: width of each per-channel saturating loss counter.

Ports:
- `clkin1`, in, 1: monitor clock (free-running reference, not a PLL output).
- `rst`, in, 1: synchronous, active-high reset.
- `lock`, in, NUM_CH: raw PLL lock inputs, asynchronous.
- `clr`, in, 1: single-cycle clear of sticky flags and loss counters.
- `locked`, out, NUM_CH: qualified lock per channel.
- `lost`, out, NUM_CH: sticky; lock dropped after being qualified.
- `timeout`, out, NUM_CH: sticky; LOCK_TIMEOUT expired without qualified lock.
- `loss_cnt`, out, NUM_CH*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W]; saturating.
- `all_locked`, out, 1: AND of `locked`.
- `chk_ok`, out, 1: `all_locked` & ~|`lost` & ~|`timeout`, registered.

## Operation
- Synchroniser:
  - SYNC_STAGES flops per channel, no reset on the first stage.
  - Last stage `lock_s[i]` is reset to 0.
- Per-channel FSM. States: WAIT, QUAL, LOCKED. Reset state is WAIT, with timer=0 and stable_cnt=0.
  - WAIT:
    - timer increments each cycle, saturating at LOCK_TIMEOUT.
    - If `lock_s`=1, go to QUAL with stable_cnt=1.
    - If STABLE_CYCLES=1, go directly to LOCKED.
  - QUAL:
    - timer keeps incrementing.
    - If `lock_s`=0, go to WAIT with stable_cnt=0. Timer is NOT cleared.
    - If `lock_s`=1 and stable_cnt=STABLE_CYCLES-1, go to LOCKED.
    - Otherwise stable_cnt++.
  - LOCKED:
    - `locked`=1. Timer is held.
    - If `lock_s`=0, go to WAIT with timer=0 and stable_cnt=0. Set `lost`, and increment loss_cnt unless it is all-ones.
- Timeout:
  - When the timer reaches LOCK_TIMEOUT in WAIT or QUAL, set `timeout` sticky.
  - The FSM continues; a later lock still reaches LOCKED.
  - `timeout` stays set until `clr` or `rst`.
- Timer width is $clog2(LOCK_TIMEOUT+1). stable_cnt width is $clog2(STABLE_CYCLES+1).
- `clr`:
  - Clears `lost`, `timeout` and all `loss_cnt`.
  - Does not touch FSM state or timers.
  - If a set event occurs in the same cycle as `clr`, the event wins: flag=1, count=1.
- `rst` mid-operation: all state returns to reset values on that edge, regardless of `lock`.
- All-channels rule: every channel is independent. `chk_ok` requires all channels healthy.

## Timing
- Reset values: `locked`=0, `lost`=0, `timeout`=0, `loss_cnt`=0, `all_locked`=0, `chk_ok`=0. The synchroniser output is 0.
- Let S = SYNC_STAGES.
- `lock_s` follows `lock` at the S-th clkin1 edge after the change.
- Lock qualification: `locked` rises at edge S+STABLE_CYCLES after `lock` rises, provided `lock` stays high.
- Loss: `locked` falls, and `lost`/`loss_cnt` update, at edge S+1 after `lock` falls.
- Glitches shorter than one clkin1 period may be missed. Loss is guaranteed detected if low ≥ 2 cycles.
- `all_locked` is combinational from `locked`.
- `chk_ok` is registered: it follows `all_locked`/`lost`/`timeout` one cycle later.
- Timeout: `timeout` sets at edge LOCK_TIMEOUT counted from the cycle after `rst` deasserts, or from the loss transition.

## Test plan
Default parameters unless stated.
- Lock rise: `rst` for 5 cycles, then ch0/ch1 `lock`=1 at cycle 10 → `locked`=2'b11 at cycle 10+3+16=29; `chk_ok`=1 at cycle 30; `timeout`=0.
- Debounce: ch0 `lock` high 10 cycles, low 2, high 40 → `locked[0]` rises only 3+16 cycles after the second rise; `lost[0]`=0; `loss_cnt[0]`=0.
- Loss and counting: after lock, drop ch1 for 5 cycles three times → `lost[1]`=1 after the first drop; `loss_cnt[1]`=3; `chk_ok`=0; `locked[1]` re-qualifies after each return.
- Timeout: ch1 `lock` held 0 → `timeout[1]`=1 at cycle 2500 after reset. Then raise `lock` → `locked[1]`=1 after 19 cycles while `timeout[1]` stays 1. `clr` → `timeout[1]`=0, `chk_ok`=1 next cycle.
- Saturation and clr collision: CNT_W=2, 5 drops → `loss_cnt`=3. Assert `clr` on the same edge as a 6th loss event → `loss_cnt`=1, `lost`=1.
- Reset mid-operation: assert `rst` during QUAL and while LOCKED → all outputs 0 on the next edge; relock timing identical to the lock-rise scenario.
